// File: rtl/digit_serial_addsub_if.sv
// Host-side handshake and operand/result bundle for the digit-serial adder/subtractor.
// The host drives the request; the engine returns status and the result.
interface digit_serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract: DIGIT bits per clock, LSB first, through one DIGIT-wide
// carry chain with a registered carry between digits.
module digit_serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input logic                   clk,
    input logic                   rst,
    digit_serial_addsub_if.slave  bus
);
    localparam int unsigned   NDIG  = WIDTH / DIGIT;
    localparam int unsigned   CW    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST  = CW'(NDIG - 1);
    // Low DIGIT bits set; all ones when DIGIT == WIDTH.
    localparam logic [WIDTH-1:0] DMASK = (WIDTH'(1) << DIGIT) - WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] opa_q, opb_q, s_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, busy_q, done_q, cout_q, ovf_q;

    int unsigned      shamt;
    logic [WIDTH-1:0] opa_sh, opb_sh, s_next;
    logic [DIGIT-1:0] dig_a, dig_b;
    logic [DIGIT:0]   dig_sum;
    logic             msb_cin;

    always_comb begin
        shamt   = int'(cnt_q) * DIGIT;
        opa_sh  = opa_q >> shamt;
        opb_sh  = opb_q >> shamt;
        dig_a   = opa_sh[DIGIT-1:0];
        dig_b   = opb_sh[DIGIT-1:0];
        dig_sum = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};
        // Carry into a bit position is recoverable as a ^ b ^ sum at that position.
        msb_cin = dig_a[DIGIT-1] ^ dig_b[DIGIT-1] ^ dig_sum[DIGIT-1];
        s_next  = (s_q & ~(DMASK << shamt)) | (WIDTH'(dig_sum[DIGIT-1:0]) << shamt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        opa_q   <= bus.a;
                        opb_q   <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.cin ^ bus.sub;
                        cnt_q   <= '0;
                        s_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    s_q     <= s_next;
                    carry_q <= dig_sum[DIGIT];
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= dig_sum[DIGIT];
                        ovf_q   <= msb_cin ^ dig_sum[DIGIT];
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: a 4-bit/1-bit-digit instance and an 8-bit/2-bit-digit
// instance, checked against plain-arithmetic expectations.
module tb_digit_serial_addsub;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    digit_serial_addsub_if #(.WIDTH(4)) bus4 ();
    digit_serial_addsub_if #(.WIDTH(8)) bus8 ();

    digit_serial_addsub #(.WIDTH(4), .DIGIT(1)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int n_cmp = 0;
    int n_err = 0;

    // Result of A +/- B +/- CIN on w-bit two's-complement operands.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub, output logic [31:0] s,
                                  output logic cout, output logic ovf);
        logic [63:0] mask, aa, bb, full;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
        full = aa + bb + 64'(cin ^ sub);
        s    = 32'(full & mask);
        cout = full[w];
        ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    endfunction

    // Clock edges until DONE is seen (bounded); sampled 1 time unit after each edge.
    task automatic wait_done(input bit use8, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(use8 ? bus8.done : bus4.done) && n < 40);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                          input logic sub);
        bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.sub = sub; bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        bus4.a = 4'($urandom); bus4.b = 4'($urandom);
        bus4.cin = 1'($urandom); bus4.sub = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus4.start = 1'b1; bus8.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus4.start = 1'b0; bus8.start = 1'b0;
        n_cmp++; if (bus4.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus4.busy); end
        n_cmp++; if (bus4.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus4.done); end
        n_cmp++; if (bus4.s !== 4'h0) begin n_err++; $display("FAIL reset_s: got %h want 0", bus4.s); end
        n_cmp++; if (bus4.cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", bus4.cout); end
        n_cmp++; if (bus4.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus4.ovf); end
        n_cmp++; if (bus8.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy8: got %b want 0", bus8.busy); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus4.busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_after: got %b want 0", bus4.busy); end
    endtask

    task automatic test_directed();
        logic [3:0] va[3]  = '{4'b0110, 4'b0111, 4'b0011};
        logic [3:0] vb[3]  = '{4'b1010, 4'b0001, 4'b0101};
        logic       vsb[3] = '{1'b0, 1'b0, 1'b1};
        logic [3:0] es[3]  = '{4'b0000, 4'b1000, 4'b1110};
        logic       ec[3]  = '{1'b1, 1'b0, 1'b0};
        logic       eo[3]  = '{1'b0, 1'b1, 1'b0};
        int n;
        for (int i = 0; i < 3; i++) begin
            issue4(va[i], vb[i], 1'b0, vsb[i]);
            n_cmp++; if (bus4.busy !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy: got %b want 1", i, bus4.busy); end
            wait_done(1'b0, n);
            n_cmp++; if (n !== 4) begin n_err++; $display("FAIL dir%0d_latency: got %0d want 4", i, n); end
            n_cmp++; if (bus4.s !== es[i]) begin n_err++; $display("FAIL dir%0d_s: got %b want %b", i, bus4.s, es[i]); end
            n_cmp++; if (bus4.cout !== ec[i]) begin n_err++; $display("FAIL dir%0d_cout: got %b want %b", i, bus4.cout, ec[i]); end
            n_cmp++; if (bus4.ovf !== eo[i]) begin n_err++; $display("FAIL dir%0d_ovf: got %b want %b", i, bus4.ovf, eo[i]); end
            @(posedge clk);
            #1;
            n_cmp++; if (bus4.done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, bus4.done); end
            n_cmp++; if (bus4.s !== es[i]) begin n_err++; $display("FAIL dir%0d_s_hold: got %b want %b", i, bus4.s, es[i]); end
        end
    endtask

    task automatic test_random();
        logic [3:0] a, b;
        logic cin, sub, ec, eo;
        logic [31:0] es;
        int n;
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            model(4, 32'(a), 32'(b), cin, sub, es, ec, eo);
            issue4(a, b, cin, sub);
            wait_done(1'b0, n);
            n_cmp++; if (n !== 4) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want 4", i, n); end
            n_cmp++; if (bus4.s !== es[3:0]) begin n_err++; $display("FAIL rnd%0d_s: got %h want %h", i, bus4.s, es[3:0]); end
            n_cmp++; if (bus4.cout !== ec) begin n_err++; $display("FAIL rnd%0d_cout: got %b want %b", i, bus4.cout, ec); end
            n_cmp++; if (bus4.ovf !== eo) begin n_err++; $display("FAIL rnd%0d_ovf: got %b want %b", i, bus4.ovf, eo); end
            // Either issue the next op in the DONE cycle or leave a short idle gap.
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_busy_ignore();
        int n, pulses;
        issue4(4'b0110, 4'b1010, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus4.start = 1'b1; bus4.a = 4'hF; bus4.b = 4'hF; bus4.cin = 1'b1; bus4.sub = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        wait_done(1'b0, n);
        n_cmp++; if (n !== 2) begin n_err++; $display("FAIL busy_latency: got %0d want 2", n); end
        n_cmp++; if (bus4.s !== 4'b0000) begin n_err++; $display("FAIL busy_s: got %b want 0000", bus4.s); end
        n_cmp++; if (bus4.cout !== 1'b1) begin n_err++; $display("FAIL busy_cout: got %b want 1", bus4.cout); end
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus4.done) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL busy_extra_done: got %0d want 0", pulses); end
        n_cmp++; if (bus4.busy !== 1'b0) begin n_err++; $display("FAIL busy_idle: got %b want 0", bus4.busy); end
    endtask

    task automatic test_reset_mid();
        int n, pulses;
        issue4(4'b0111, 4'b0001, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (bus4.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", bus4.busy); end
        n_cmp++; if (bus4.s !== 4'h0) begin n_err++; $display("FAIL abort_s: got %h want 0", bus4.s); end
        pulses = 0;
        repeat (8) begin
            if (bus4.done) pulses++;
            @(posedge clk);
            #1;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL abort_done: got %0d want 0", pulses); end
        issue4(4'b0011, 4'b0101, 1'b0, 1'b1);
        wait_done(1'b0, n);
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL abort_fresh_latency: got %0d want 4", n); end
        n_cmp++; if (bus4.s !== 4'b1110) begin n_err++; $display("FAIL abort_fresh_s: got %b want 1110", bus4.s); end
        n_cmp++; if (bus4.cout !== 1'b0) begin n_err++; $display("FAIL abort_fresh_cout: got %b want 0", bus4.cout); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        logic cin, sub, ec, eo;
        logic [31:0] es;
        int n;
        bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b1; bus8.sub = 1'b0; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        wait_done(1'b1, n);
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL b2b0_latency: got %0d want 4", n); end
        n_cmp++; if (bus8.s !== 8'h01) begin n_err++; $display("FAIL b2b0_s: got %h want 01", bus8.s); end
        n_cmp++; if (bus8.cout !== 1'b1) begin n_err++; $display("FAIL b2b0_cout: got %b want 1", bus8.cout); end
        n_cmp++; if (bus8.ovf !== 1'b0) begin n_err++; $display("FAIL b2b0_ovf: got %b want 0", bus8.ovf); end
        for (int i = 1; i <= 6; i++) begin
            // Start is raised while DONE is high: must be taken with no idle cycle.
            a = (i == 1) ? 8'h80 : 8'($urandom);
            b = (i == 1) ? 8'h01 : 8'($urandom);
            cin = (i == 1) ? 1'b0 : 1'($urandom);
            sub = (i == 1) ? 1'b1 : 1'($urandom);
            model(8, 32'(a), 32'(b), cin, sub, es, ec, eo);
            bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.start = 1'b1;
            @(posedge clk);
            #1;
            bus8.start = 1'b0;
            n_cmp++; if (bus8.busy !== 1'b1) begin n_err++; $display("FAIL b2b%0d_busy: got %b want 1", i, bus8.busy); end
            n_cmp++; if (bus8.done !== 1'b0) begin n_err++; $display("FAIL b2b%0d_done_low: got %b want 0", i, bus8.done); end
            wait_done(1'b1, n);
            n_cmp++; if (n !== 4) begin n_err++; $display("FAIL b2b%0d_latency: got %0d want 4", i, n); end
            n_cmp++; if (bus8.s !== es[7:0]) begin n_err++; $display("FAIL b2b%0d_s: got %h want %h", i, bus8.s, es[7:0]); end
            n_cmp++; if (bus8.cout !== ec) begin n_err++; $display("FAIL b2b%0d_cout: got %b want %b", i, bus8.cout, ec); end
            n_cmp++; if (bus8.ovf !== eo) begin n_err++; $display("FAIL b2b%0d_ovf: got %b want %b", i, bus8.ovf, eo); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
